cv32e40p_pc_redirect_sequencer: RTL and testbench

Registered controller that drives the fetch-address selection datapath: it arbitrates all PC redirect requests (boot, jump, branch, exceptions, interrupts, debug, returns, fence.i, hardware loop), holds the chosen `pc_mux`/`exc_pc_mux`/`trap_addr_mux` selection stable until the fetch stage accepts it, and sequences boot, fence.i drain and debug halt. It sits between the controller/decode request sources and the PC selection mux in the IF stage.

---
 rtl/cv32e40p_pc_redirect_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cv32e40p_pc_redirect_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_pc_redirect_sequencer.sv
// cv32e40p_pc_redirect_sequencer
//
// Arbitrates PC redirect requests and holds the chosen fetch-address selection
// stable until the IF stage accepts it. Also sequences boot, fence.i drain and
// debug halt.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_enable_i        leave IDLE and issue the boot redirect
//   fetch_ready_i         IF accepts the redirect presented this cycle
//   fence_idle_i          memory side drained (ends fence.i wait)
//   *_req_i               level redirect requests, held until acked
//   irq_id_i, trap_user_i interrupt index / user-mode target for exc and irq
//   pc_set_o              redirect valid to IF
//   pc_mux_o, exc_pc_mux_o, trap_addr_mux_o, m/u_exc_vec_pc_mux_o  selections
//   ack_o                 one-hot completion pulse, bit order:
//                         [0]hwlp [1]jump [2]branch [3]fencei [4]uret
//                         [5]mret [6]dret [7]irq [8]exc [9]debug
//   flush_o               high while waiting for the fence drain
//   debug_mode_o          core halted in debug
//   csr_mtvec_init_o      pulse when the boot redirect is accepted
module cv32e40p_pc_redirect_sequencer #(
  parameter int N_IRQ_ID = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_enable_i,
  input  logic                fetch_ready_i,
  input  logic                fence_idle_i,
  input  logic                debug_req_i,
  input  logic                exc_req_i,
  input  logic                irq_req_i,
  input  logic                mret_req_i,
  input  logic                uret_req_i,
  input  logic                dret_req_i,
  input  logic                fencei_req_i,
  input  logic                branch_req_i,
  input  logic                jump_req_i,
  input  logic                hwlp_req_i,
  input  logic [N_IRQ_ID-1:0] irq_id_i,
  input  logic                trap_user_i,
  output logic                pc_set_o,
  output logic [3:0]          pc_mux_o,
  output logic [2:0]          exc_pc_mux_o,
  output logic [1:0]          trap_addr_mux_o,
  output logic [N_IRQ_ID-1:0] m_exc_vec_pc_mux_o,
  output logic [N_IRQ_ID-1:0] u_exc_vec_pc_mux_o,
  output logic [9:0]          ack_o,
  output logic                flush_o,
  output logic                debug_mode_o,
  output logic                csr_mtvec_init_o
);

  localparam logic [3:0] PC_BOOT      = 4'd0;
  localparam logic [3:0] PC_FENCEI    = 4'd1;
  localparam logic [3:0] PC_JUMP      = 4'd2;
  localparam logic [3:0] PC_BRANCH    = 4'd3;
  localparam logic [3:0] PC_EXCEPTION = 4'd4;
  localparam logic [3:0] PC_MRET      = 4'd5;
  localparam logic [3:0] PC_URET      = 4'd6;
  localparam logic [3:0] PC_DRET      = 4'd7;
  localparam logic [3:0] PC_HWLOOP    = 4'd8;

  localparam logic [2:0] EXC_PC_EXCEPTION = 3'd0;
  localparam logic [2:0] EXC_PC_IRQ       = 3'd1;
  localparam logic [2:0] EXC_PC_DBD       = 3'd2;
  localparam logic [2:0] EXC_PC_DBE       = 3'd3;

  localparam logic [1:0] TRAP_MACHINE = 2'd0;
  localparam logic [1:0] TRAP_USER    = 2'd1;

  // Bit positions inside the request/grant/ack vectors.
  localparam int B_FENCEI = 3;
  localparam int B_DRET   = 6;
  localparam int B_IRQ    = 7;
  localparam int B_EXC    = 8;
  localparam int B_DEBUG  = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOOT       = 3'd1,
    RUN        = 3'd2,
    HOLD       = 3'd3,
    FENCE_WAIT = 3'd4,
    DEBUG      = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          pc_mux_reg, pc_mux_next;
  logic [2:0]          exc_pc_mux_reg, exc_pc_mux_next;
  logic [1:0]          trap_addr_reg, trap_addr_next;
  logic [N_IRQ_ID-1:0] m_vec_reg, m_vec_next;
  logic [N_IRQ_ID-1:0] u_vec_reg, u_vec_next;
  logic [9:0]          winner_reg, winner_next;
  logic                debug_mode_reg, debug_mode_next;

  // Request vector is laid out in ack bit order, which is also priority
  // order: the highest set bit wins.
  logic [9:0] req;
  logic [9:0] grant;

  assign req = {debug_req_i, exc_req_i, irq_req_i, dret_req_i, mret_req_i,
                uret_req_i, fencei_req_i, branch_req_i, jump_req_i, hwlp_req_i};

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_grant
      if (gi == 9) begin : g_top
        assign grant[gi] = req[gi];
      end else begin : g_lower
        assign grant[gi] = req[gi] & ~(|req[9:gi+1]);
      end
    end
  endgenerate

  // Selection implied by the RUN-state winner.
  logic [3:0]          sel_pc_mux;
  logic [2:0]          sel_exc_pc_mux;
  logic [1:0]          sel_trap;
  logic [N_IRQ_ID-1:0] sel_m_vec;
  logic [N_IRQ_ID-1:0] sel_u_vec;

  always_comb begin
    sel_pc_mux     = PC_BOOT;
    sel_exc_pc_mux = EXC_PC_EXCEPTION;
    sel_trap       = TRAP_MACHINE;
    sel_m_vec      = '0;
    sel_u_vec      = '0;
    if (grant[9]) begin
      sel_pc_mux     = PC_EXCEPTION;
      sel_exc_pc_mux = EXC_PC_DBD;
    end else if (grant[8]) begin
      sel_pc_mux     = PC_EXCEPTION;
      sel_exc_pc_mux = EXC_PC_EXCEPTION;
      sel_trap       = trap_user_i ? TRAP_USER : TRAP_MACHINE;
    end else if (grant[7]) begin
      sel_pc_mux     = PC_EXCEPTION;
      sel_exc_pc_mux = EXC_PC_IRQ;
      sel_trap       = trap_user_i ? TRAP_USER : TRAP_MACHINE;
      if (trap_user_i) sel_u_vec = irq_id_i;
      else             sel_m_vec = irq_id_i;
    end else if (grant[6]) begin
      sel_pc_mux = PC_DRET;
    end else if (grant[5]) begin
      sel_pc_mux = PC_MRET;
    end else if (grant[4]) begin
      sel_pc_mux = PC_URET;
    end else if (grant[3]) begin
      sel_pc_mux = PC_FENCEI;
    end else if (grant[2]) begin
      sel_pc_mux = PC_BRANCH;
    end else if (grant[1]) begin
      sel_pc_mux = PC_JUMP;
    end else if (grant[0]) begin
      sel_pc_mux = PC_HWLOOP;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_mux_next     = pc_mux_reg;
    exc_pc_mux_next = exc_pc_mux_reg;
    trap_addr_next  = trap_addr_reg;
    m_vec_next      = m_vec_reg;
    u_vec_next      = u_vec_reg;
    winner_next     = winner_reg;
    debug_mode_next = debug_mode_reg;

    case (state_reg)
      IDLE: begin
        if (fetch_enable_i) begin
          state_next  = BOOT;
          pc_mux_next = PC_BOOT;
        end
      end

      BOOT: begin
        if (fetch_ready_i) state_next = RUN;
      end

      RUN: begin
        if (|req) begin
          winner_next     = grant;
          pc_mux_next     = sel_pc_mux;
          exc_pc_mux_next = sel_exc_pc_mux;
          trap_addr_next  = sel_trap;
          m_vec_next      = sel_m_vec;
          u_vec_next      = sel_u_vec;
          state_next      = grant[B_FENCEI] ? FENCE_WAIT : HOLD;
        end
      end

      HOLD: begin
        if (fetch_ready_i) begin
          if (winner_reg[B_DEBUG]) begin
            state_next      = DEBUG;
            debug_mode_next = 1'b1;
          end else if (winner_reg[B_DRET]) begin
            state_next      = RUN;
            debug_mode_next = 1'b0;
          end else if (debug_mode_reg) begin
            // Exception taken while halted: return to the debug loop.
            state_next = DEBUG;
          end else begin
            state_next = RUN;
          end
        end
      end

      FENCE_WAIT: begin
        if (fence_idle_i) state_next = HOLD;
      end

      DEBUG: begin
        if (dret_req_i) begin
          winner_next     = 10'b1 << B_DRET;
          pc_mux_next     = PC_DRET;
          exc_pc_mux_next = EXC_PC_EXCEPTION;
          trap_addr_next  = TRAP_MACHINE;
          m_vec_next      = '0;
          u_vec_next      = '0;
          state_next      = HOLD;
        end else if (exc_req_i) begin
          winner_next     = 10'b1 << B_EXC;
          pc_mux_next     = PC_EXCEPTION;
          exc_pc_mux_next = EXC_PC_DBE;
          trap_addr_next  = trap_user_i ? TRAP_USER : TRAP_MACHINE;
          m_vec_next      = '0;
          u_vec_next      = '0;
          state_next      = HOLD;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_mux_reg     <= PC_BOOT;
      exc_pc_mux_reg <= EXC_PC_EXCEPTION;
      trap_addr_reg  <= TRAP_MACHINE;
      m_vec_reg      <= '0;
      u_vec_reg      <= '0;
      winner_reg     <= '0;
      debug_mode_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_mux_reg     <= pc_mux_next;
      exc_pc_mux_reg <= exc_pc_mux_next;
      trap_addr_reg  <= trap_addr_next;
      m_vec_reg      <= m_vec_next;
      u_vec_reg      <= u_vec_next;
      winner_reg     <= winner_next;
      debug_mode_reg <= debug_mode_next;
    end
  end

  // pc_set_o depends on state only; the acceptance pulses need fetch_ready_i
  // because completion is defined as the cycle IF takes the redirect.
  assign pc_set_o           = (state_reg == BOOT) || (state_reg == HOLD);
  assign pc_mux_o           = pc_mux_reg;
  assign exc_pc_mux_o       = exc_pc_mux_reg;
  assign trap_addr_mux_o    = trap_addr_reg;
  assign m_exc_vec_pc_mux_o = m_vec_reg;
  assign u_exc_vec_pc_mux_o = u_vec_reg;
  assign ack_o              = ((state_reg == HOLD) && fetch_ready_i) ? winner_reg : '0;
  assign flush_o            = (state_reg == FENCE_WAIT);
  assign debug_mode_o       = debug_mode_reg;
  assign csr_mtvec_init_o   = (state_reg == BOOT) && fetch_ready_i;

  // B_IRQ documents the irq bit position used in the grant vector.
  logic unused_irq_bit;
  assign unused_irq_bit = grant[B_IRQ] & 1'b0;

endmodule

// File: tb/tb_cv32e40p_pc_redirect_sequencer.sv
module tb_cv32e40p_pc_redirect_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_enable_i, fetch_ready_i, fence_idle_i;
  logic       debug_req_i, exc_req_i, irq_req_i, mret_req_i, uret_req_i;
  logic       dret_req_i, fencei_req_i, branch_req_i, jump_req_i, hwlp_req_i;
  logic [4:0] irq_id_i;
  logic       trap_user_i;
  logic       pc_set_o;
  logic [3:0] pc_mux_o;
  logic [2:0] exc_pc_mux_o;
  logic [1:0] trap_addr_mux_o;
  logic [4:0] m_exc_vec_pc_mux_o, u_exc_vec_pc_mux_o;
  logic [9:0] ack_o;
  logic       flush_o, debug_mode_o, csr_mtvec_init_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cv32e40p_pc_redirect_sequencer #(.N_IRQ_ID(5)) dut (
    .clk(clk), .rst(rst),
    .fetch_enable_i(fetch_enable_i), .fetch_ready_i(fetch_ready_i),
    .fence_idle_i(fence_idle_i),
    .debug_req_i(debug_req_i), .exc_req_i(exc_req_i), .irq_req_i(irq_req_i),
    .mret_req_i(mret_req_i), .uret_req_i(uret_req_i), .dret_req_i(dret_req_i),
    .fencei_req_i(fencei_req_i), .branch_req_i(branch_req_i),
    .jump_req_i(jump_req_i), .hwlp_req_i(hwlp_req_i),
    .irq_id_i(irq_id_i), .trap_user_i(trap_user_i),
    .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o), .exc_pc_mux_o(exc_pc_mux_o),
    .trap_addr_mux_o(trap_addr_mux_o),
    .m_exc_vec_pc_mux_o(m_exc_vec_pc_mux_o), .u_exc_vec_pc_mux_o(u_exc_vec_pc_mux_o),
    .ack_o(ack_o), .flush_o(flush_o), .debug_mode_o(debug_mode_o),
    .csr_mtvec_init_o(csr_mtvec_init_o)
  );

  // Advance one cycle; inputs are driven and outputs observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_set: got %0h expected 0", pc_set_o); end
    n_checks++; if (pc_mux_o !== 4'd0) begin n_fail++; $display("FAIL reset_pc_mux: got %0h expected 0", pc_mux_o); end
    n_checks++; if (exc_pc_mux_o !== 3'd0) begin n_fail++; $display("FAIL reset_exc_pc_mux: got %0h expected 0", exc_pc_mux_o); end
    n_checks++; if (trap_addr_mux_o !== 2'd0) begin n_fail++; $display("FAIL reset_trap: got %0h expected 0", trap_addr_mux_o); end
    n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL reset_ack: got %0h expected 0", ack_o); end
    n_checks++; if ({flush_o, debug_mode_o, csr_mtvec_init_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {flush_o, debug_mode_o, csr_mtvec_init_o}); end
    n_checks++; if ({m_exc_vec_pc_mux_o, u_exc_vec_pc_mux_o} !== 10'h000) begin n_fail++; $display("FAIL reset_vec: got %0h expected 0", {m_exc_vec_pc_mux_o, u_exc_vec_pc_mux_o}); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_boot();
    fetch_enable_i = 1'b1;
    fetch_ready_i  = 1'b1;
    #1;
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL boot_no_comb_path: got %0h expected 0", pc_set_o); end
    tick();
    n_checks++; if (pc_set_o !== 1'b1) begin n_fail++; $display("FAIL boot_pc_set: got %0h expected 1", pc_set_o); end
    n_checks++; if (pc_mux_o !== 4'd0) begin n_fail++; $display("FAIL boot_pc_mux: got %0h expected 0", pc_mux_o); end
    n_checks++; if (csr_mtvec_init_o !== 1'b1) begin n_fail++; $display("FAIL boot_mtvec_init: got %0h expected 1", csr_mtvec_init_o); end
    tick();
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL boot_run_pc_set: got %0h expected 0", pc_set_o); end
    n_checks++; if (csr_mtvec_init_o !== 1'b0) begin n_fail++; $display("FAIL boot_mtvec_single: got %0h expected 0", csr_mtvec_init_o); end
    $display("test_boot done");
  endtask

  task automatic test_branch_jump();
    fetch_ready_i = 1'b0;
    branch_req_i  = 1'b1;
    jump_req_i    = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pc_set_o !== 1'b1) begin n_fail++; $display("FAIL bj_hold_pc_set[%0d]: got %0h expected 1", i, pc_set_o); end
      n_checks++; if (pc_mux_o !== 4'd3) begin n_fail++; $display("FAIL bj_hold_pc_mux[%0d]: got %0h expected 3", i, pc_mux_o); end
      n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL bj_hold_ack[%0d]: got %0h expected 0", i, ack_o); end
      tick();
    end
    fetch_ready_i = 1'b1;
    #1;
    n_checks++; if (pc_set_o !== 1'b1) begin n_fail++; $display("FAIL bj_fourth_pc_set: got %0h expected 1", pc_set_o); end
    n_checks++; if (ack_o !== 10'h004) begin n_fail++; $display("FAIL bj_branch_ack: got %0h expected 004", ack_o); end
    tick();
    branch_req_i = 1'b0;
    #1;
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL bj_run_gap: got %0h expected 0", pc_set_o); end
    n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL bj_run_ack: got %0h expected 0", ack_o); end
    tick();
    n_checks++; if (pc_mux_o !== 4'd2) begin n_fail++; $display("FAIL bj_jump_pc_mux: got %0h expected 2", pc_mux_o); end
    n_checks++; if (ack_o !== 10'h002) begin n_fail++; $display("FAIL bj_jump_ack: got %0h expected 002", ack_o); end
    tick();
    jump_req_i = 1'b0;
    #1;
    n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL bj_idle_ack: got %0h expected 0", ack_o); end
    $display("test_branch_jump done");
  endtask

  task automatic test_irq();
    fetch_ready_i = 1'b0;
    irq_req_i     = 1'b1;
    irq_id_i      = 5'd11;
    trap_user_i   = 1'b1;
    tick();
    n_checks++; if (pc_mux_o !== 4'd4) begin n_fail++; $display("FAIL irq_pc_mux: got %0h expected 4", pc_mux_o); end
    n_checks++; if (exc_pc_mux_o !== 3'd1) begin n_fail++; $display("FAIL irq_exc_pc_mux: got %0h expected 1", exc_pc_mux_o); end
    n_checks++; if (trap_addr_mux_o !== 2'd1) begin n_fail++; $display("FAIL irq_trap: got %0h expected 1", trap_addr_mux_o); end
    n_checks++; if (u_exc_vec_pc_mux_o !== 5'd11) begin n_fail++; $display("FAIL irq_u_vec: got %0d expected 11", u_exc_vec_pc_mux_o); end
    n_checks++; if (m_exc_vec_pc_mux_o !== 5'd0) begin n_fail++; $display("FAIL irq_m_vec: got %0d expected 0", m_exc_vec_pc_mux_o); end
    fetch_ready_i = 1'b1;
    #1;
    n_checks++; if (ack_o !== 10'h080) begin n_fail++; $display("FAIL irq_ack: got %0h expected 080", ack_o); end
    tick();
    irq_req_i   = 1'b0;
    trap_user_i = 1'b0;
    irq_id_i    = 5'd0;
    $display("test_irq done");
  endtask

  task automatic test_fencei();
    fetch_ready_i = 1'b1;
    fence_idle_i  = 1'b0;
    fencei_req_i  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) exc_req_i = 1'b1;  // must wait for the fence to finish
      if (i == 4) fence_idle_i = 1'b1;
      #1;
      n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL fence_flush[%0d]: got %0h expected 1", i, flush_o); end
      n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL fence_pc_set[%0d]: got %0h expected 0", i, pc_set_o); end
      n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL fence_ack[%0d]: got %0h expected 0", i, ack_o); end
      tick();
    end
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL fence_flush_drop: got %0h expected 0", flush_o); end
    n_checks++; if (pc_mux_o !== 4'd1) begin n_fail++; $display("FAIL fence_pc_mux: got %0h expected 1", pc_mux_o); end
    n_checks++; if (ack_o !== 10'h008) begin n_fail++; $display("FAIL fence_ack_done: got %0h expected 008", ack_o); end
    tick();
    fencei_req_i = 1'b0;
    fence_idle_i = 1'b0;
    tick();
    n_checks++; if ({pc_mux_o, exc_pc_mux_o, trap_addr_mux_o} !== {4'd4, 3'd0, 2'd0}) begin n_fail++; $display("FAIL exc_after_fence_sel: got %0h/%0h/%0h expected 4/0/0", pc_mux_o, exc_pc_mux_o, trap_addr_mux_o); end
    n_checks++; if (ack_o !== 10'h100) begin n_fail++; $display("FAIL exc_after_fence_ack: got %0h expected 100", ack_o); end
    tick();
    exc_req_i = 1'b0;
    $display("test_fencei done");
  endtask

  task automatic test_debug();
    fetch_ready_i = 1'b1;
    debug_req_i   = 1'b1;
    tick();
    n_checks++; if ({pc_mux_o, exc_pc_mux_o} !== {4'd4, 3'd2}) begin n_fail++; $display("FAIL dbg_entry_sel: got %0h/%0h expected 4/2", pc_mux_o, exc_pc_mux_o); end
    n_checks++; if (ack_o !== 10'h200) begin n_fail++; $display("FAIL dbg_entry_ack: got %0h expected 200", ack_o); end
    tick();
    debug_req_i = 1'b0;
    #1;
    n_checks++; if (debug_mode_o !== 1'b1) begin n_fail++; $display("FAIL dbg_mode_set: got %0h expected 1", debug_mode_o); end
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL dbg_halt_pc_set: got %0h expected 0", pc_set_o); end
    irq_req_i   = 1'b1;
    debug_req_i = 1'b1;
    tick();
    n_checks++; if ({pc_set_o, ack_o} !== 11'h000) begin n_fail++; $display("FAIL dbg_ignore_irq: got %0h/%0h expected 0/0", pc_set_o, ack_o); end
    exc_req_i = 1'b1;
    tick();
    n_checks++; if ({pc_mux_o, exc_pc_mux_o} !== {4'd4, 3'd3}) begin n_fail++; $display("FAIL dbg_exc_sel: got %0h/%0h expected 4/3", pc_mux_o, exc_pc_mux_o); end
    n_checks++; if (ack_o !== 10'h100) begin n_fail++; $display("FAIL dbg_exc_ack: got %0h expected 100", ack_o); end
    tick();
    exc_req_i = 1'b0;
    #1;
    n_checks++; if ({debug_mode_o, pc_set_o} !== 2'b10) begin n_fail++; $display("FAIL dbg_exc_return: got %b expected 10", {debug_mode_o, pc_set_o}); end
    dret_req_i = 1'b1;
    exc_req_i  = 1'b1;
    tick();
    n_checks++; if (pc_mux_o !== 4'd7) begin n_fail++; $display("FAIL dret_pc_mux: got %0h expected 7", pc_mux_o); end
    n_checks++; if (ack_o !== 10'h040) begin n_fail++; $display("FAIL dret_ack: got %0h expected 040", ack_o); end
    tick();
    dret_req_i  = 1'b0;
    exc_req_i   = 1'b0;
    irq_req_i   = 1'b0;
    debug_req_i = 1'b0;
    #1;
    n_checks++; if (debug_mode_o !== 1'b0) begin n_fail++; $display("FAIL dret_mode_clear: got %0h expected 0", debug_mode_o); end
    tick();
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL dret_run_idle: got %0h expected 0", pc_set_o); end
    $display("test_debug done");
  endtask

  task automatic test_reset_in_hold();
    fetch_ready_i = 1'b0;
    branch_req_i  = 1'b1;
    tick();
    n_checks++; if (pc_set_o !== 1'b1) begin n_fail++; $display("FAIL rsthold_pre: got %0h expected 1", pc_set_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (ack_o !== 10'h000) begin n_fail++; $display("FAIL rsthold_no_ack: got %0h expected 0", ack_o); end
    tick();
    n_checks++; if ({pc_set_o, pc_mux_o, ack_o, flush_o, debug_mode_o} !== 17'h0) begin n_fail++; $display("FAIL rsthold_cleared: got %0h/%0h/%0h expected 0/0/0", pc_set_o, pc_mux_o, ack_o); end
    branch_req_i   = 1'b0;
    fetch_enable_i = 1'b0;
    rst            = 1'b0;
    tick();
    n_checks++; if (pc_set_o !== 1'b0) begin n_fail++; $display("FAIL rsthold_idle: got %0h expected 0", pc_set_o); end
    $display("test_reset_in_hold done");
  endtask

  initial begin
    rst = 1'b1;
    fetch_enable_i = 1'b0; fetch_ready_i = 1'b0; fence_idle_i = 1'b0;
    debug_req_i = 1'b0; exc_req_i = 1'b0; irq_req_i = 1'b0; mret_req_i = 1'b0;
    uret_req_i = 1'b0; dret_req_i = 1'b0; fencei_req_i = 1'b0;
    branch_req_i = 1'b0; jump_req_i = 1'b0; hwlp_req_i = 1'b0;
    irq_id_i = 5'd0; trap_user_i = 1'b0;
    test_reset();
    test_boot();
    test_branch_jump();
    test_irq();
    test_fencei();
    test_debug();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
